// File: rtl/rgb2hsv.sv
`timescale 1ns/1ps
// Pipelined RGB888 -> HSV (H stored as hue/2) converter, fixed 20-cycle latency.
// Two 16-step restoring dividers produce S = 255*d/max and the in-sector hue fraction 30*x/d.
module rgb2hsv (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pre_rgb,
  input  logic        pre_hs,
  input  logic        pre_vs,
  input  logic        pre_clken,
  output logic [23:0] post_hsv,
  output logic [23:0] post_rgb,
  output logic        post_hs,
  output logic        post_vs,
  output logic        post_clken
);

  localparam int NDIV = 16;
  localparam int NDLY = 20;

  logic [7:0] r_in, g_in, b_in;
  assign r_in = pre_rgb[23:16];
  assign g_in = pre_rgb[15:8];
  assign b_in = pre_rgb[7:0];

  // stage 1: max/min/mid and sector
  logic [7:0]  max1_d, min1_d, mid1_d;
  logic [2:0]  sec1_d;
  logic [7:0]  max1_q, min1_q, mid1_q;
  logic [2:0]  sec1_q;
  logic [23:0] rgb1_q;

  // stage 2: range and in-sector offset
  logic [7:0]  d2_d, x2_d;
  logic [7:0]  d2_q, x2_q, max2_q;
  logic [2:0]  sec2_q;
  logic [23:0] rgb2_q;

  // divider pipeline: index 0 is stage 3, index NDIV is stage 19
  logic [7:0]  srem_q [0:NDIV];
  logic [7:0]  hrem_q [0:NDIV];
  logic [15:0] snum_q [0:NDIV];
  logic [15:0] hnum_q [0:NDIV];
  logic [15:0] squo_q [0:NDIV];
  logic [15:0] hquo_q [0:NDIV];
  logic [7:0]  sdiv_q [0:NDIV];
  logic [7:0]  hdiv_q [0:NDIV];
  logic        szero_q[0:NDIV];
  logic        hzero_q[0:NDIV];
  logic [2:0]  sec_q  [0:NDIV];
  logic [23:0] rgbp_q [0:NDIV];

  logic [7:0]  srem_d [0:NDIV];
  logic [7:0]  hrem_d [0:NDIV];
  logic [15:0] snum_d [0:NDIV];
  logic [15:0] hnum_d [0:NDIV];
  logic [15:0] squo_d [0:NDIV];
  logic [15:0] hquo_d [0:NDIV];

  logic [23:0] hsv_d, hsv_q, orgb_q;
  logic [7:0]  hue_d, sat_d;
  logic [NDLY-1:0] hs_q, vs_q, ck_q;

  // returns {quotient bit, new remainder}; true remainder is < divisor so 8 bits suffice
  function automatic logic [8:0] div_step(input logic [7:0] rem, input logic nbit,
                                          input logic [7:0] dvs);
    logic [8:0] t;
    t = {rem, nbit};
    if (t >= {1'b0, dvs}) div_step = {1'b1, t[7:0] - dvs};
    else                  div_step = {1'b0, t[7:0]};
  endfunction

  always_comb begin
    max1_d = r_in;
    min1_d = b_in;
    mid1_d = g_in;
    sec1_d = 3'd0;
    if (r_in >= g_in && g_in >= b_in) begin
      max1_d = r_in; mid1_d = g_in; min1_d = b_in; sec1_d = 3'd0;
    end else if (g_in > r_in && r_in >= b_in) begin
      max1_d = g_in; mid1_d = r_in; min1_d = b_in; sec1_d = 3'd1;
    end else if (g_in >= b_in && b_in > r_in) begin
      max1_d = g_in; mid1_d = b_in; min1_d = r_in; sec1_d = 3'd2;
    end else if (b_in > g_in && g_in > r_in) begin
      max1_d = b_in; mid1_d = g_in; min1_d = r_in; sec1_d = 3'd3;
    end else if (b_in > r_in && r_in >= g_in) begin
      max1_d = b_in; mid1_d = r_in; min1_d = g_in; sec1_d = 3'd4;
    end else begin
      max1_d = r_in; mid1_d = b_in; min1_d = g_in; sec1_d = 3'd5;
    end
  end

  assign d2_d = max1_q - min1_q;
  assign x2_d = sec1_q[0] ? (max1_q - mid1_q) : (mid1_q - min1_q);

  always_comb begin
    logic [8:0] sstep, hstep;
    sstep = 9'd0;
    hstep = 9'd0;
    srem_d[0] = 8'd0;
    hrem_d[0] = 8'd0;
    snum_d[0] = {8'd0, d2_q} * 16'd255;
    hnum_d[0] = {8'd0, x2_q} * 16'd30;
    squo_d[0] = 16'd0;
    hquo_d[0] = 16'd0;
    for (int s = 0; s < NDIV; s++) begin
      sstep = div_step(srem_q[s], snum_q[s][15], sdiv_q[s]);
      hstep = div_step(hrem_q[s], hnum_q[s][15], hdiv_q[s]);
      srem_d[s+1] = sstep[7:0];
      hrem_d[s+1] = hstep[7:0];
      snum_d[s+1] = {snum_q[s][14:0], 1'b0};
      hnum_d[s+1] = {hnum_q[s][14:0], 1'b0};
      squo_d[s+1] = {squo_q[s][14:0], sstep[8]};
      hquo_d[s+1] = {hquo_q[s][14:0], hstep[8]};
    end
  end

  // zero-divisor flags override whatever the divider produced
  assign sat_d = szero_q[NDIV] ? 8'd0 : squo_q[NDIV][7:0];
  assign hue_d = hzero_q[NDIV] ? 8'd0
               : (8'(sec_q[NDIV]) * 8'd30) + hquo_q[NDIV][7:0];
  assign hsv_d = {hue_d, sat_d, sdiv_q[NDIV]};

  always_ff @(posedge clk) begin
    if (rst) begin
      max1_q <= '0; min1_q <= '0; mid1_q <= '0; sec1_q <= '0; rgb1_q <= '0;
      d2_q   <= '0; x2_q   <= '0; max2_q <= '0; sec2_q <= '0; rgb2_q <= '0;
      for (int s = 0; s <= NDIV; s++) begin
        srem_q[s]  <= '0; hrem_q[s]  <= '0;
        snum_q[s]  <= '0; hnum_q[s]  <= '0;
        squo_q[s]  <= '0; hquo_q[s]  <= '0;
        sdiv_q[s]  <= '0; hdiv_q[s]  <= '0;
        szero_q[s] <= 1'b0; hzero_q[s] <= 1'b0;
        sec_q[s]   <= '0; rgbp_q[s]  <= '0;
      end
      hsv_q  <= '0;
      orgb_q <= '0;
      hs_q   <= '0;
      vs_q   <= '0;
      ck_q   <= '0;
    end else begin
      max1_q <= max1_d; min1_q <= min1_d; mid1_q <= mid1_d;
      sec1_q <= sec1_d; rgb1_q <= pre_rgb;
      d2_q   <= d2_d;   x2_q   <= x2_d;   max2_q <= max1_q;
      sec2_q <= sec1_q; rgb2_q <= rgb1_q;
      sdiv_q[0]  <= max2_q;
      hdiv_q[0]  <= d2_q;
      szero_q[0] <= (max2_q == 8'd0);
      hzero_q[0] <= (d2_q == 8'd0);
      sec_q[0]   <= sec2_q;
      rgbp_q[0]  <= rgb2_q;
      for (int s = 0; s <= NDIV; s++) begin
        srem_q[s] <= srem_d[s]; hrem_q[s] <= hrem_d[s];
        snum_q[s] <= snum_d[s]; hnum_q[s] <= hnum_d[s];
        squo_q[s] <= squo_d[s]; hquo_q[s] <= hquo_d[s];
      end
      for (int s = 1; s <= NDIV; s++) begin
        sdiv_q[s]  <= sdiv_q[s-1];  hdiv_q[s]  <= hdiv_q[s-1];
        szero_q[s] <= szero_q[s-1]; hzero_q[s] <= hzero_q[s-1];
        sec_q[s]   <= sec_q[s-1];   rgbp_q[s]  <= rgbp_q[s-1];
      end
      hsv_q  <= hsv_d;
      orgb_q <= rgbp_q[NDIV];
      hs_q   <= {hs_q[NDLY-2:0], pre_hs};
      vs_q   <= {vs_q[NDLY-2:0], pre_vs};
      ck_q   <= {ck_q[NDLY-2:0], pre_clken};
    end
  end

  // final remainders/shifted numerators and quotient bits [15:8] are zero or don't-care by range
  logic unused_div;
  assign unused_div = ^{srem_q[NDIV], hrem_q[NDIV], snum_q[NDIV], hnum_q[NDIV],
                        squo_q[NDIV][15:8], hquo_q[NDIV][15:8]};

  assign post_hsv   = hsv_q;
  assign post_rgb   = orgb_q;
  assign post_hs    = hs_q[NDLY-1];
  assign post_vs    = vs_q[NDLY-1];
  assign post_clken = ck_q[NDLY-1];

endmodule

// File: tb/tb_rgb2hsv.sv
`timescale 1ns/1ps
// Scoreboard bench for rgb2hsv: directed pixels, sync/latency alignment, mid-stream reset
// and a hue-ramp round trip through a reference hsv2rgb model.
module tb_rgb2hsv;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pre_rgb;
  logic        pre_hs, pre_vs, pre_clken;
  logic [23:0] post_hsv, post_rgb;
  logic        post_hs, post_vs, post_clken;

  rgb2hsv dut (
    .clk(clk), .rst(rst),
    .pre_rgb(pre_rgb), .pre_hs(pre_hs), .pre_vs(pre_vs), .pre_clken(pre_clken),
    .post_hsv(post_hsv), .post_rgb(post_rgb),
    .post_hs(post_hs), .post_vs(post_vs), .post_clken(post_clken)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [23:0] rgb;
    logic [23:0] hsv;
    logic        hs;
    logic        vs;
    bit          rt;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [23:0] hsv2rgb(input logic [23:0] hsv);
    int h, s, v, rg, f, p, q, t, r, g, b;
    h = int'(hsv[23:16]); s = int'(hsv[15:8]); v = int'(hsv[7:0]);
    rg = h / 30;
    f  = (h % 30) * 255 / 30;
    p  = v * (255 - s) / 255;
    q  = v * (65025 - s * f) / 65025;
    t  = v * (65025 - s * (255 - f)) / 65025;
    case (rg)
      0:       begin r = v; g = t; b = p; end
      1:       begin r = q; g = v; b = p; end
      2:       begin r = p; g = v; b = t; end
      3:       begin r = p; g = q; b = v; end
      4:       begin r = t; g = p; b = v; end
      default: begin r = v; g = p; b = q; end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic drive(input logic r, input logic [23:0] rgb, input logic ck,
                       input logic hs, input logic vs, input bit rt, input logic [23:0] eh);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; pre_rgb = rgb; pre_clken = ck; pre_hs = hs; pre_vs = vs;
    if (!r && ck) begin
      e.rgb = rgb; e.hsv = eh; e.hs = hs; e.vs = vs; e.rt = rt; e.cyc = cyc + 20;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  // in-flight pixels are discarded by reset
  always @(posedge clk) if (rst === 1'b1) sb.delete();

  exp_t        m_e;
  logic [23:0] m_rec;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL missing_out: got no post_clken expected pixel 0x%0h at cycle %0d",
               sb[0].rgb, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (rst !== 1'b1) begin
      if (post_clken === 1'b1) begin
        if (sb.size() == 0) chk("unexpected_clken", 32'(post_clken), 32'd0);
        else begin
          m_e = sb.pop_front();
          chk("latency", 32'(cyc), 32'(m_e.cyc));
          chk("post_rgb", 32'(post_rgb), 32'(m_e.rgb));
          if (m_e.rt) begin
            m_rec = hsv2rgb(post_hsv);
            for (int c = 0; c < 3; c++) begin
              int a, o;
              a = int'(m_rec[c*8 +: 8]);
              o = int'(m_e.rgb[c*8 +: 8]);
              total++;
              if (a - o > 4 || o - a > 4) begin
                bad++;
                $display("FAIL roundtrip ch%0d: got %0d expected %0d+-4 (hsv 0x%0h)",
                         c, a, o, post_hsv);
              end
            end
          end else chk("post_hsv", 32'(post_hsv), 32'(m_e.hsv));
          chk("post_hs", 32'(post_hs), 32'(m_e.hs));
          chk("post_vs", 32'(post_vs), 32'(m_e.vs));
        end
      end else chk("idle_sync", 32'({post_hs, post_vs}), 32'd0);
    end
  end

  localparam int NV = 15;
  logic [23:0] vin [NV];
  logic [23:0] vexp[NV];

  initial begin
    vin  = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'hFF00FF,
             24'h808080, 24'h000000, 24'hFFFFFF, {8'd200, 8'd100, 8'd50},
             {8'd0, 8'd100, 8'd200}, {8'd200, 8'd50, 8'd100}, {8'd50, 8'd200, 8'd100},
             {8'd100, 8'd200, 8'd50}, {8'd100, 8'd50, 8'd200}, {8'd1, 8'd0, 8'd0}};
    vexp = '{{8'd0, 8'd255, 8'd255}, {8'd60, 8'd255, 8'd255}, {8'd120, 8'd255, 8'd255},
             {8'd30, 8'd255, 8'd255}, {8'd150, 8'd255, 8'd255},
             {8'd0, 8'd0, 8'd128}, {8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd255},
             {8'd10, 8'd191, 8'd200},
             {8'd105, 8'd255, 8'd200}, {8'd170, 8'd191, 8'd200}, {8'd70, 8'd191, 8'd200},
             {8'd50, 8'd191, 8'd200}, {8'd130, 8'd191, 8'd200}, {8'd0, 8'd255, 8'd1}};

    rst = 1'b1; pre_rgb = 24'hABCDEF; pre_clken = 1'b1; pre_hs = 1'b1; pre_vs = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hsv",   32'(post_hsv), 32'd0);
    chk("rst_rgb",   32'(post_rgb), 32'd0);
    chk("rst_clken", 32'(post_clken), 32'd0);
    chk("rst_hs",    32'(post_hs), 32'd0);
    chk("rst_vs",    32'(post_vs), 32'd0);

    // isolated directed pixels
    for (int i = 0; i < NV; i++) begin
      drive(1'b0, vin[i], 1'b1, 1'b0, 1'b0, 1'b0, vexp[i]);
      idle(2);
    end
    idle(22);

    // single-cycle sync pulses
    drive(1'b0, 24'h123456, 1'b1, 1'b1, 1'b0, 1'b0, {8'd105, 8'd201, 8'd86});
    idle(25);
    drive(1'b0, 24'h123456, 1'b1, 1'b0, 1'b1, 1'b0, {8'd105, 8'd201, 8'd86});
    idle(25);

    // back-to-back stream
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) drive(1'b0, {3{8'(i * 3)}}, 1'b1, 1'b0, 1'b0, 1'b0, {16'd0, 8'(i * 3)});
      else            drive(1'b0, vin[(i / 2) % NV], 1'b1, 1'b0, 1'b0, 1'b0, vexp[(i / 2) % NV]);
    end

    // one-cycle reset inside a continuous stream
    for (int i = 0; i < 16; i++) drive(1'b0, vin[i % NV], 1'b1, 1'b0, 1'b0, 1'b0, vexp[i % NV]);
    drive(1'b1, vin[0], 1'b1, 1'b1, 1'b1, 1'b0, vexp[0]);
    drive(1'b0, vin[1], 1'b1, 1'b0, 1'b0, 1'b0, vexp[1]);
    @(negedge clk);
    chk("midrst_hsv",   32'(post_hsv), 32'd0);
    chk("midrst_rgb",   32'(post_rgb), 32'd0);
    chk("midrst_clken", 32'(post_clken), 32'd0);
    chk("midrst_hs",    32'(post_hs), 32'd0);
    chk("midrst_vs",    32'(post_vs), 32'd0);
    for (int i = 2; i < 40; i++) drive(1'b0, vin[i % NV], 1'b1, 1'b0, 1'b0, 1'b0, vexp[i % NV]);

    // hue ramp over all six sectors, mid channel at multiples of 17
    for (int m = 1; m < 15; m += 4) begin
      logic [7:0] u, dn;
      u  = 8'(17 * m);
      dn = 8'(255 - 17 * m);
      drive(1'b0, {8'd255, u, 8'd0},  1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
      drive(1'b0, {dn, 8'd255, 8'd0}, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
      drive(1'b0, {8'd0, 8'd255, u},  1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
      drive(1'b0, {8'd0, dn, 8'd255}, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
      drive(1'b0, {u, 8'd0, 8'd255},  1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
      drive(1'b0, {8'd255, 8'd0, dn}, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
    end
    idle(30);

    chk("drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
